// File: rtl/uart_reg_bridge.sv
// uart_reg_bridge: UART-driven bank of NUM_REGS control registers, REG_W bits each.
// Frames are 0xA5, ADDR, then NB data bytes for a write (MSB first) or nothing for a read.
// Replies are ACK 0x06, NAK 0x15, or the register's NB bytes.
// Optional macro BRIDGE_CHKSUM_EN adds a trailing XOR check byte to requests and replies.
module uart_reg_bridge #(
  parameter int          CLK_HZ       = 50000000,
  parameter int          BAUD         = 115200,
  parameter int          NUM_REGS     = 4,
  parameter int          REG_W        = 22,
  parameter logic [31:0] RESET_VAL    = 32'd0,
  parameter int          TIMEOUT_BITS = 256
) (
  input  logic                      clk_clk,
  input  logic                      reset_reset,
  input  logic                      uart_rxd,
  output logic                      uart_txd,
  output logic [NUM_REGS*REG_W-1:0] regs_out,
  output logic [NUM_REGS-1:0]       reg_wr_stb,
  output logic                      frame_err
);

  localparam int DIV    = CLK_HZ / BAUD;
  localparam int NB     = (REG_W + 7) / 8;
  localparam int SH_W   = NB * 8;
  localparam int CNT_W  = $clog2(DIV);
  localparam int TO_CYC = TIMEOUT_BITS * DIV;
  localparam int TO_W   = $clog2(TO_CYC + 1);
  localparam int IDX_W  = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam int BUF_N  = NB + 1;
  localparam int BI_W   = $clog2(BUF_N);
  localparam int LEN_W  = $clog2(BUF_N + 1);
  localparam int BC_W   = (NB > 1) ? $clog2(NB) : 1;
`ifdef BRIDGE_CHKSUM_EN
  localparam int CHK_N  = 1;
`else
  localparam int CHK_N  = 0;
`endif
  localparam logic [REG_W-1:0] RST_V   = RESET_VAL[REG_W-1:0];
  localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(DIV / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(DIV - 1);
  localparam logic [TO_W-1:0]  TO_M1   = TO_W'(TO_CYC - 1);
  localparam logic [7:0] HDR = 8'hA5;
  localparam logic [7:0] ACK = 8'h06;
  localparam logic [7:0] NAK = 8'h15;

  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAIT_HI} rx_state_t;
  typedef enum logic [2:0] {
    P_IDLE, P_ADDR, P_DATA,
`ifdef BRIDGE_CHKSUM_EN
    P_CHK,
`endif
    P_EXEC, P_REPLY
  } p_state_t;

`ifdef BRIDGE_CHKSUM_EN
  localparam p_state_t P_AFTER_PAYLOAD = P_CHK;
`else
  localparam p_state_t P_AFTER_PAYLOAD = P_EXEC;
`endif

  logic [1:0]       r_rst_sync;
  logic             w_rst;
  logic [1:0]       r_rxd_sync;
  logic             w_rxd;
  rx_state_t        r_rx_state;
  logic [CNT_W-1:0] r_rx_cnt;
  logic [2:0]       r_rx_bit;
  logic [7:0]       r_rx_shift;
  logic             w_rx_tick, w_rx_valid, w_rx_ferr;
  logic [7:0]       w_rx_byte;

  p_state_t         r_p_state;
  logic [REG_W-1:0] r_regs [NUM_REGS];
  logic [IDX_W-1:0] r_idx;
  logic             r_is_read;
  logic [SH_W-1:0]  r_data_sh;
  logic [BC_W-1:0]  r_byte_cnt;
  logic [TO_W-1:0]  r_to_cnt;
  logic [7:0]       r_tx_buf [BUF_N];
  logic [LEN_W-1:0] r_tx_len;
  logic             r_tx_start;
  logic [NUM_REGS-1:0] r_wr_stb;
  logic             r_frame_err;
  logic             w_in_frame;
  logic [SH_W-1:0]  w_rd_pad;
`ifdef BRIDGE_CHKSUM_EN
  logic [7:0]       r_chk;
`endif

  logic [9:0]       r_tx_frame;
  logic [CNT_W-1:0] r_tx_cnt;
  logic [3:0]       r_tx_bit;
  logic [BI_W-1:0]  r_tx_idx;
  logic [LEN_W-1:0] r_tx_left;
  logic             r_tx_busy;

  function automatic logic [7:0] xor_bytes(input logic [SH_W-1:0] v);
    logic [7:0] acc;
    acc = '0;
    for (int k = 0; k < NB; k++) acc ^= v[k*8 +: 8];
    return acc;
  endfunction

  // Reset: asserts immediately, releases on a clock edge.
  // NOTE: flops use <= so every register sees pre-edge values; = is kept for function temporaries.
  always_ff @(posedge clk_clk or posedge reset_reset)
    if (reset_reset) r_rst_sync <= 2'b11;
    else             r_rst_sync <= {r_rst_sync[0], 1'b0};
  assign w_rst = r_rst_sync[1];

  // Two-flop synchroniser for the asynchronous serial input (idles high).
  always_ff @(posedge clk_clk or posedge w_rst)
    if (w_rst) r_rxd_sync <= 2'b11;
    else       r_rxd_sync <= {r_rxd_sync[0], uart_rxd};
  assign w_rxd = r_rxd_sync[1];

  assign w_rx_tick  = (r_rx_cnt == FULL_M1);
  assign w_rx_valid = (r_rx_state == RX_STOP) && w_rx_tick && w_rxd;
  assign w_rx_ferr  = (r_rx_state == RX_STOP) && w_rx_tick && !w_rxd;
  assign w_rx_byte  = r_rx_shift;

  // RX bit engine: start-bit recheck at half period, data and stop sampled at bit centres.
  always_ff @(posedge clk_clk or posedge w_rst)
    if (w_rst) begin
      r_rx_state <= RX_IDLE;
      r_rx_cnt   <= '0;
      r_rx_bit   <= '0;
      r_rx_shift <= '0;
    end else begin
      case (r_rx_state)
        RX_IDLE: begin
          r_rx_cnt <= '0;
          if (!w_rxd) r_rx_state <= RX_START;
        end
        RX_START:
          if (r_rx_cnt == HALF_M1) begin
            r_rx_cnt   <= '0;
            r_rx_bit   <= '0;
            r_rx_state <= w_rxd ? RX_IDLE : RX_DATA;
          end else r_rx_cnt <= r_rx_cnt + 1'b1;
        RX_DATA:
          if (w_rx_tick) begin
            r_rx_cnt   <= '0;
            r_rx_shift <= {w_rxd, r_rx_shift[7:1]};
            r_rx_bit   <= r_rx_bit + 1'b1;
            if (r_rx_bit == 3'd7) r_rx_state <= RX_STOP;
          end else r_rx_cnt <= r_rx_cnt + 1'b1;
        RX_STOP:
          if (w_rx_tick) begin
            r_rx_cnt   <= '0;
            r_rx_state <= w_rxd ? RX_IDLE : RX_WAIT_HI;
          end else r_rx_cnt <= r_rx_cnt + 1'b1;
        RX_WAIT_HI: if (w_rxd) r_rx_state <= RX_IDLE;
        default:    r_rx_state <= RX_IDLE;
      endcase
    end

`ifdef BRIDGE_CHKSUM_EN
  assign w_in_frame = (r_p_state == P_ADDR) || (r_p_state == P_DATA) || (r_p_state == P_CHK);
`else
  assign w_in_frame = (r_p_state == P_ADDR) || (r_p_state == P_DATA);
`endif
  assign w_rd_pad = SH_W'(r_regs[r_idx]);

  // Frame parser: owns the register bank, strobes, error pulse and the reply buffer.
  always_ff @(posedge clk_clk or posedge w_rst)
    if (w_rst) begin
      r_p_state   <= P_IDLE;
      // NOTE: the bank is plain flops driving datapath controls, so every entry gets a reset value.
      for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= RST_V;
      for (int i = 0; i < BUF_N; i++) r_tx_buf[i] <= '0;
      r_idx       <= '0;
      r_is_read   <= 1'b0;
      r_data_sh   <= '0;
      r_byte_cnt  <= '0;
      r_to_cnt    <= '0;
      r_tx_len    <= '0;
      r_tx_start  <= 1'b0;
      r_wr_stb    <= '0;
      r_frame_err <= 1'b0;
`ifdef BRIDGE_CHKSUM_EN
      r_chk       <= '0;
`endif
    end else begin
      r_wr_stb    <= '0;
      r_tx_start  <= 1'b0;
      r_frame_err <= w_rx_ferr;
      // Inter-byte timeout abandons the frame silently apart from the error pulse.
      if (w_in_frame && !w_rx_valid) begin
        if (r_to_cnt == TO_M1) begin
          r_frame_err <= 1'b1;
          r_p_state   <= P_IDLE;
        end else r_to_cnt <= r_to_cnt + 1'b1;
      end
      case (r_p_state)
        P_IDLE:
          if (w_rx_valid && w_rx_byte == HDR) begin
            r_to_cnt  <= '0;
            r_p_state <= P_ADDR;
          end
        P_ADDR:
          if (w_rx_valid) begin
            r_to_cnt   <= '0;
            r_is_read  <= w_rx_byte[7];
            r_idx      <= w_rx_byte[IDX_W-1:0];
            r_data_sh  <= '0;
            r_byte_cnt <= '0;
`ifdef BRIDGE_CHKSUM_EN
            r_chk      <= w_rx_byte;
`endif
            if (int'(w_rx_byte[6:0]) >= NUM_REGS) begin
              r_frame_err <= 1'b1;
              r_tx_buf[0] <= NAK;
              r_tx_buf[1] <= NAK;
              r_tx_len    <= LEN_W'(1 + CHK_N);
              r_tx_start  <= 1'b1;
              r_p_state   <= P_REPLY;
            end else if (w_rx_byte[7]) r_p_state <= P_AFTER_PAYLOAD;
            else                       r_p_state <= P_DATA;
          end
        P_DATA:
          if (w_rx_valid) begin
            r_to_cnt   <= '0;
            r_data_sh  <= SH_W'({r_data_sh, w_rx_byte});
            r_byte_cnt <= r_byte_cnt + 1'b1;
`ifdef BRIDGE_CHKSUM_EN
            r_chk      <= r_chk ^ w_rx_byte;
`endif
            if (r_byte_cnt == BC_W'(NB - 1)) r_p_state <= P_AFTER_PAYLOAD;
          end
`ifdef BRIDGE_CHKSUM_EN
        P_CHK:
          if (w_rx_valid) begin
            if (w_rx_byte == r_chk) r_p_state <= P_EXEC;
            else begin
              r_frame_err <= 1'b1;
              r_tx_buf[0] <= NAK;
              r_tx_buf[1] <= NAK;
              r_tx_len    <= LEN_W'(2);
              r_tx_start  <= 1'b1;
              r_p_state   <= P_REPLY;
            end
          end
`endif
        P_EXEC: begin
          if (r_is_read) begin
            for (int k = 0; k < NB; k++) r_tx_buf[k] <= w_rd_pad[(NB-1-k)*8 +: 8];
            r_tx_buf[NB] <= xor_bytes(w_rd_pad);
            r_tx_len     <= LEN_W'(NB + CHK_N);
          end else begin
            r_regs[r_idx]   <= r_data_sh[REG_W-1:0];
            r_wr_stb[r_idx] <= 1'b1;
            r_tx_buf[0]     <= ACK;
            r_tx_buf[1]     <= ACK;
            r_tx_len        <= LEN_W'(1 + CHK_N);
          end
          r_tx_start <= 1'b1;
          r_p_state  <= P_REPLY;
        end
        P_REPLY: if (!r_tx_busy && !r_tx_start) r_p_state <= P_IDLE;
        default: r_p_state <= P_IDLE;
      endcase
    end

  // TX engine: 8N1 frames from the reply buffer, next byte loaded right after each stop bit.
  always_ff @(posedge clk_clk or posedge w_rst)
    if (w_rst) begin
      r_tx_frame <= '1;
      r_tx_cnt   <= '0;
      r_tx_bit   <= '0;
      r_tx_idx   <= '0;
      r_tx_left  <= '0;
      r_tx_busy  <= 1'b0;
    end else if (!r_tx_busy) begin
      if (r_tx_start) begin
        r_tx_frame <= {1'b1, r_tx_buf[0], 1'b0};
        r_tx_idx   <= BI_W'(1);
        r_tx_left  <= r_tx_len - 1'b1;
        r_tx_cnt   <= '0;
        r_tx_bit   <= '0;
        r_tx_busy  <= 1'b1;
      end
    end else if (r_tx_cnt == FULL_M1) begin
      r_tx_cnt <= '0;
      if (r_tx_bit == 4'd9) begin
        if (r_tx_left != '0) begin
          r_tx_frame <= {1'b1, r_tx_buf[r_tx_idx], 1'b0};
          r_tx_idx   <= r_tx_idx + 1'b1;
          r_tx_left  <= r_tx_left - 1'b1;
          r_tx_bit   <= '0;
        end else begin
          r_tx_frame <= '1;
          r_tx_busy  <= 1'b0;
        end
      end else begin
        r_tx_frame <= {1'b1, r_tx_frame[9:1]};
        r_tx_bit   <= r_tx_bit + 1'b1;
      end
    end else r_tx_cnt <= r_tx_cnt + 1'b1;

  assign uart_txd   = r_tx_frame[0];
  assign reg_wr_stb = r_wr_stb;
  assign frame_err  = r_frame_err;

  for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_out
    assign regs_out[gi*REG_W +: REG_W] = r_regs[gi];
  end

endmodule

// File: tb/tb_uart_reg_bridge.sv
// Directed bench for uart_reg_bridge at DIV=10, four 22-bit registers, checksum off.
module tb_uart_reg_bridge;
  localparam int DIV = 10;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rxd = 1'b1;
  logic        txd;
  logic [87:0] regs_out;
  logic [3:0]  stb;
  logic        ferr;

  always #5 clk = ~clk;

  uart_reg_bridge #(
    .CLK_HZ(1000000), .BAUD(100000), .NUM_REGS(4), .REG_W(22),
    .RESET_VAL(32'd0), .TIMEOUT_BITS(256)
  ) dut (
    .clk_clk(clk), .reset_reset(rst), .uart_rxd(rxd), .uart_txd(txd),
    .regs_out(regs_out), .reg_wr_stb(stb), .frame_err(ferr)
  );

  int n_checks = 0;
  int n_errors = 0;
  logic [7:0] tx_q [$];
  logic [3:0] stb_q [$];
  int ferr_cnt = 0;
  int tx_rd = 0;

  task automatic check(input string tag, input logic [87:0] got, input logic [87:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [87:0] pack4(input logic [21:0] r0, r1, r2, r3);
    return {r3, r2, r1, r0};
  endfunction

  // Strobe and error pulse logging, sampled mid-cycle.
  always @(negedge clk) begin
    if (stb != 4'b0) stb_q.push_back(stb);
    if (ferr) ferr_cnt++;
  end

  // Serial decoder for the reply line.
  initial begin : tx_mon
    logic [7:0] b;
    forever begin
      @(negedge clk);
      if (txd === 1'b0 && !rst) begin
        repeat (4) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
          repeat (DIV) @(negedge clk);
          b[i] = txd;
        end
        repeat (DIV) @(negedge clk);
        tx_q.push_back(b);
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input logic stop_bit = 1'b1);
    rxd = 1'b0;
    repeat (DIV) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      repeat (DIV) @(negedge clk);
    end
    rxd = stop_bit;
    repeat (DIV) @(negedge clk);
    rxd = 1'b1;
  endtask

  // Waits for n reply bytes (bounded), then compares count and contents MSB-first from exp.
  task automatic expect_reply(input string tag, input int n, input logic [23:0] exp);
    int waited;
    logic [7:0] got;
    waited = 0;
    while (tx_q.size() < tx_rd + n && waited < 1500) begin
      @(negedge clk);
      waited++;
    end
    repeat (150) @(negedge clk);
    check({tag, "_len"}, tx_q.size() - tx_rd, n);
    for (int k = 0; k < n; k++) begin
      if (tx_rd + k < tx_q.size()) got = tx_q[tx_rd + k];
      else                         got = 8'hxx;
      check($sformatf("%s_b%0d", tag, k), got, exp[23-8*k -: 8]);
    end
    tx_rd = tx_q.size();
  endtask

  initial begin
    int s0, f0;
    logic [3:0] stb_got;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_txd", txd, 1'b1);
    check("rst_regs", regs_out, '0);
    check("rst_stb", stb, 4'b0);
    check("rst_ferr", ferr, 1'b0);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    // Write register 2
    s0 = stb_q.size(); f0 = ferr_cnt;
    send_byte(8'hA5); send_byte(8'h02); send_byte(8'h12); send_byte(8'h34); send_byte(8'h56);
    expect_reply("wr_ack", 1, 24'h060000);
    check("wr_regs", regs_out, pack4(22'h0, 22'h0, 22'h123456, 22'h0));
    check("wr_stb_n", stb_q.size() - s0, 1);
    stb_got = (stb_q.size() > s0) ? stb_q[s0] : 4'bxxxx;
    check("wr_stb", stb_got, 4'b0100);
    check("wr_ferr", ferr_cnt - f0, 0);

    // Read back registers 2 and 1
    send_byte(8'hA5); send_byte(8'h82);
    expect_reply("rd2", 3, 24'h123456);
    send_byte(8'hA5); send_byte(8'h81);
    expect_reply("rd1", 3, 24'h000000);

    // Width truncation on register 0
    send_byte(8'hA5); send_byte(8'h00); send_byte(8'hFF); send_byte(8'hFF); send_byte(8'hFF);
    expect_reply("trunc_ack", 1, 24'h060000);
    check("trunc_regs", regs_out, pack4(22'h3FFFFF, 22'h0, 22'h123456, 22'h0));

    // Bad index
    f0 = ferr_cnt;
    send_byte(8'hA5); send_byte(8'h05);
    expect_reply("badidx", 1, 24'h150000);
    check("badidx_ferr", ferr_cnt - f0, 1);
    check("badidx_regs", regs_out, pack4(22'h3FFFFF, 22'h0, 22'h123456, 22'h0));

    // Stop bit forced low on the header: it must be discarded, so the rest is ignored
    f0 = ferr_cnt;
    send_byte(8'hA5, 1'b0);
    repeat (2 * DIV) @(negedge clk);
    send_byte(8'h02); send_byte(8'h12); send_byte(8'h34); send_byte(8'h56);
    repeat (200) @(negedge clk);
    check("stoperr_ferr", ferr_cnt - f0, 1);
    expect_reply("stoperr", 0, 24'h0);
    check("stoperr_regs", regs_out, pack4(22'h3FFFFF, 22'h0, 22'h123456, 22'h0));

    // Inter-byte timeout mid-write
    f0 = ferr_cnt;
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'hAA);
    repeat (2400) @(negedge clk);
    check("to_early", ferr_cnt - f0, 0);
    repeat (300) @(negedge clk);
    check("to_ferr", ferr_cnt - f0, 1);
    check("to_noreply", tx_q.size() - tx_rd, 0);
    check("to_regs", regs_out, pack4(22'h3FFFFF, 22'h0, 22'h123456, 22'h0));

    // Reset during the second reply byte (bit 3 of 0x34 is low)
    send_byte(8'hA5); send_byte(8'h82);
    repeat (145) @(negedge clk);
    check("midtx_txd", txd, 1'b0);
    #2 rst = 1'b1;
    #1;
    check("midtx_rst_txd", txd, 1'b1);
    check("midtx_rst_regs", regs_out, '0);
    check("midtx_rst_stb", stb, 4'b0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (300) @(negedge clk);
    tx_rd = tx_q.size();

    // A fresh frame is accepted after reset
    s0 = stb_q.size();
    send_byte(8'hA5); send_byte(8'h03); send_byte(8'h00); send_byte(8'h00); send_byte(8'h07);
    expect_reply("post_ack", 1, 24'h060000);
    check("post_regs", regs_out, pack4(22'h0, 22'h0, 22'h0, 22'h7));
    stb_got = (stb_q.size() > s0) ? stb_q[s0] : 4'bxxxx;
    check("post_stb", stb_got, 4'b1000);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached before completion");
    $fatal(1);
  end

endmodule
